// File: rtl/pi_cfg_pkg.sv
// pi_cfg_pkg
//   Shared constants for the RPi serial configuration receiver: frame width,
//   sync nibble, field bit positions inside the 16-bit command frame and the
//   bit-counter sizing.
//   Ports: none (package).
package pi_cfg_pkg;

  localparam int          CFG_FRAME_W = 16;
  localparam logic [3:0]  CFG_SYNC    = 4'hA;

  // Field positions in the frame (bit 15 is shifted in first).
  localparam int SYNC_MSB = 15;
  localparam int SYNC_LSB = 12;
  localparam int K0_MSB   = 11;
  localparam int K0_LSB   = 10;
  localparam int K1_MSB   = 9;
  localparam int K1_LSB   = 8;
  localparam int C_MSB    = 7;
  localparam int C_LSB    = 6;
  localparam int EN0_BIT  = 5;
  localparam int EN1_BIT  = 4;
  localparam int DAT_MSB  = 3;
  localparam int DAT_LSB  = 2;
  localparam int RSV_BIT  = 1;
  localparam int PAR_BIT  = 0;

  // Bit counter saturates one past a full frame so over-length frames
  // stay distinguishable from exact 16-bit frames.
  localparam int             BIT_CNT_W    = 5;
  localparam logic [4:0]     BIT_CNT_FULL = 5'd16;
  localparam logic [4:0]     BIT_CNT_OVER = 5'd17;

endpackage

// File: rtl/pi_cfg_rx_sync_rise.sv
// sync_rise
//   Multi-flop synchronizer for one asynchronous input plus a rising-edge
//   detector on the synchronized level.
//   Ports:
//     i_clk      system clock
//     i_rst_n    asynchronous active-low reset (clears all flops to 0)
//     i_d        asynchronous input
//     o_level_s  synchronized level (last synchronizer stage)
//     o_rise     one-cycle pulse when o_level_s goes 0 -> 1
//   STAGES must be at least 2.
module sync_rise #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level_s,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level_s = r_sync[STAGES-1];
  assign o_rise    = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/pi_cfg_rx.sv
// pi_cfg_rx
//   Receives a 16-bit configuration frame from the RPi (bit clock + serial
//   data, MSB first), and on the rising edge of the latch strobe checks it
//   (length, sync nibble, reserved bit, even parity). Good frames drive the
//   DUT control pins; bad frames leave them untouched and set a sticky error.
//   A partial frame left idle for TIMEOUT_CYC cycles is discarded.
//   Ports:
//     CLK, RST_B           system clock, async active-low reset
//     data_clk_cfg_pi      RPi bit clock (async, sampled on rise)
//     data_in_cfg_pi       RPi serial data (async)
//     latch_cfg_pi         RPi apply strobe (async, acts on rise)
//     K0, K1, C            clock-gen controls
//     enable0, enable1     chip enables (0 = EXT)
//     dat_ctl              DUT data-pattern select
//     cfg_valid            single-cycle pulse on the cycle the outputs update;
//                          no back-pressure, consumers must take it that cycle
//     cfg_status_pi        1 when the last latched frame was accepted
//     frame_err            sticky error, cleared by the next accepted frame
module pi_cfg_rx
  import pi_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT_CYC = 5000000,
  parameter logic [1:0] RST_K       = 2'b11,
  parameter logic [1:0] RST_C       = 2'b00,
  parameter logic [1:0] RST_DAT     = 2'b00
) (
  input  logic       CLK,
  input  logic       RST_B,
  input  logic       data_clk_cfg_pi,
  input  logic       data_in_cfg_pi,
  input  logic       latch_cfg_pi,
  output logic [1:0] K0,
  output logic [1:0] K1,
  output logic [1:0] C,
  output logic       enable0,
  output logic       enable1,
  output logic [1:0] dat_ctl,
  output logic       cfg_valid,
  output logic       cfg_status_pi,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  // Synchronized inputs. data_in uses the same depth as data_clk so the
  // sampled bit lines up with the detected clock edge.
  logic w_dclk_rise;
  logic w_dclk_level_unused;
  logic w_latch_rise;
  logic w_latch_level_unused;
  logic w_din_s;
  logic w_din_rise_unused;

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_dclk (
    .i_clk     (CLK),
    .i_rst_n   (RST_B),
    .i_d       (data_clk_cfg_pi),
    .o_level_s (w_dclk_level_unused),
    .o_rise    (w_dclk_rise)
  );

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .i_clk     (CLK),
    .i_rst_n   (RST_B),
    .i_d       (latch_cfg_pi),
    .o_level_s (w_latch_level_unused),
    .o_rise    (w_latch_rise)
  );

  sync_rise #(.STAGES(SYNC_STAGES)) u_sync_din (
    .i_clk     (CLK),
    .i_rst_n   (RST_B),
    .i_d       (data_in_cfg_pi),
    .o_level_s (w_din_s),
    .o_rise    (w_din_rise_unused)
  );

  logic [CFG_FRAME_W-1:0] r_shreg;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [IDLE_W-1:0]      r_idle_cnt;
  logic [1:0]             r_k0, r_k1, r_c, r_dat;
  logic                   r_en0, r_en1;
  logic                   r_valid, r_status, r_err;

  logic [CFG_FRAME_W-1:0] w_shreg_nxt;
  logic [BIT_CNT_W-1:0]   w_cnt_nxt;
  logic                   w_frame_ok;
  logic                   w_timeout;

  // Shift and count are evaluated before the latch check so a bit clock and
  // a latch rising in the same cycle still see the complete frame.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_bit_cnt;
    if (w_dclk_rise) begin
      w_shreg_nxt = {r_shreg[CFG_FRAME_W-2:0], w_din_s};
      if (r_bit_cnt != BIT_CNT_OVER) begin
        w_cnt_nxt = r_bit_cnt + 1'b1;
      end
    end
  end

  assign w_frame_ok = (w_cnt_nxt == BIT_CNT_FULL)
                    && (w_shreg_nxt[SYNC_MSB:SYNC_LSB] == CFG_SYNC)
                    && !w_shreg_nxt[RSV_BIT]
                    && !(^w_shreg_nxt);

  assign w_timeout = (r_bit_cnt != '0) && !w_dclk_rise
                   && (r_idle_cnt == IDLE_W'(TIMEOUT_CYC));

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_idle_cnt <= '0;
      r_k0       <= RST_K;
      r_k1       <= RST_K;
      r_c        <= RST_C;
      r_en0      <= 1'b0;
      r_en1      <= 1'b0;
      r_dat      <= RST_DAT;
      r_valid    <= 1'b0;
      r_status   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_valid <= 1'b0;
      if (w_latch_rise) begin
        r_bit_cnt  <= '0;
        r_idle_cnt <= '0;
        if (w_frame_ok) begin
          r_k0     <= w_shreg_nxt[K0_MSB:K0_LSB];
          r_k1     <= w_shreg_nxt[K1_MSB:K1_LSB];
          r_c      <= w_shreg_nxt[C_MSB:C_LSB];
          r_en0    <= w_shreg_nxt[EN0_BIT];
          r_en1    <= w_shreg_nxt[EN1_BIT];
          r_dat    <= w_shreg_nxt[DAT_MSB:DAT_LSB];
          r_valid  <= 1'b1;
          r_status <= 1'b1;
          r_err    <= 1'b0;
        end else begin
          r_status <= 1'b0;
          r_err    <= 1'b1;
        end
      end else if (w_timeout) begin
        // Stale partial frame: drop it, flag it, keep the applied config.
        r_bit_cnt  <= '0;
        r_idle_cnt <= '0;
        r_err      <= 1'b1;
      end else begin
        r_bit_cnt <= w_cnt_nxt;
        if (w_dclk_rise || (r_bit_cnt == '0)) begin
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign K0            = r_k0;
  assign K1            = r_k1;
  assign C             = r_c;
  assign enable0       = r_en0;
  assign enable1       = r_en1;
  assign dat_ctl       = r_dat;
  assign cfg_valid     = r_valid;
  assign cfg_status_pi = r_status;
  assign frame_err     = r_err;

endmodule

// File: doc/pi_cfg_rx.md
Name: pi_cfg_rx

Overview:
- Serial configuration receiver. It is the inbound counterpart of the RPi data-readout shifters.
- The RPi clocks a 16-bit command frame in on data_clk_cfg_pi / data_in_cfg_pi and then raises latch_cfg_pi.
- The block synchronizes these into the CLK domain, checks the frame, and drives the DUT control pins (K0/K1, C, enable0/enable1) plus the data-pattern select for the DUT data generator.
- Rejected frames leave all outputs unchanged and raise a sticky error flag that the RPi can read.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for all three RPi inputs. Must be ≥2.
- TIMEOUT_CYC, 5000000: idle CLK cycles (100 ms at 50 MHz) after which a partial frame is discarded.
- RST_K, 2'b11: reset value of K0 and K1 (external clock).
- RST_C, 2'b00: reset value of C.
- RST_DAT, 2'b00: reset value of dat_ctl.

Ports:
- CLK  in  1  system clock (clk_50m_sys).
- RST_B  in  1  asynchronous, active-low reset.
- data_clk_cfg_pi  in  1  RPi bit clock. Asynchronous; the frame bit is sampled on its rising edge.
- data_in_cfg_pi  in  1  RPi serial data, MSB first. Asynchronous.
- latch_cfg_pi  in  1  RPi frame-apply strobe. Asynchronous; acts on its rising edge.
- K0  out  2  clock-gen control, chip 0.
- K1  out  2  clock-gen control, chip 1.
- C  out  2  internal clock-gen frequency control, shared by both chips.
- enable0  out  1  chip 0 enable (0 = EXT).
- enable1  out  1  chip 1 enable (0 = EXT).
- dat_ctl  out  2  DUT data-pattern select.
- cfg_valid  out  1  one-cycle pulse when a frame is applied.
- cfg_status_pi  out  1  1 when the last latched frame was accepted.
- frame_err  out  1  sticky error flag, cleared by the next accepted frame.

Behaviour:
- Frame format (bit 15 sent first):
  - [15:12] sync nibble, must be 4'hA.
  - [11:10] K0, [9:8] K1, [7:6] C.
  - [5] enable0, [4] enable1.
  - [3:2] dat_ctl.
  - [1] reserved, must be 0.
  - [0] even parity: total number of 1s over [15:0] is even.
- Reset values (RST_B low, asynchronous):
  - K0 = K1 = RST_K, C = RST_C, enable0 = enable1 = 0, dat_ctl = RST_DAT.
  - cfg_valid = 0, cfg_status_pi = 0, frame_err = 0.
  - Shift register, bit counter and timeout counter are cleared; synchronizer flops are cleared to 0.
- Synchronization and edge detect:
  - Each input passes through SYNC_STAGES flops. Rising edge is detected as sync_last & ~prev.
  - data_in uses the same depth as data_clk, so the two stay aligned.
  - RPi high and low times must each be ≥ SYNC_STAGES+1 CLK periods.
- Shifting:
  - On each detected data_clk rise: shreg <= {shreg[14:0], data_in_s}.
  - bit_cnt increments and saturates at 17; 17 means over-length.
- Latch handling, on a detected latch rise:
  - Accept only if bit_cnt == 16, shreg[15:12] == 4'hA, shreg[1] == 0 and parity is even.
  - Accept: register the fields onto the outputs, cfg_valid = 1 for exactly one cycle, cfg_status_pi = 1, frame_err = 0.
  - Reject: outputs hold, frame_err = 1, cfg_status_pi = 0.
  - In both cases bit_cnt is cleared to 0.
- Latency: outputs and cfg_valid change on the CLK edge SYNC_STAGES+1 edges after the first edge that samples latch_cfg_pi high.
- Simultaneous data_clk rise and latch rise in the same cycle: the shift is applied first, and the check uses the updated shreg and bit_cnt.
- Latch with bit_cnt == 0: this is a reject and sets frame_err.
- Timeout:
  - idle_cnt counts cycles while bit_cnt ≠ 0 and resets on every data_clk rise.
  - On reaching TIMEOUT_CYC: bit_cnt is cleared and frame_err is set; outputs hold.
  - idle_cnt width is $clog2(TIMEOUT_CYC+1).
- Reset mid-frame: the partial frame is lost and outputs return to their reset values immediately.

Decomposition:
- Package pi_cfg_pkg holds:
  - CFG_FRAME_W = 16 and CFG_SYNC = 4'hA.
  - Field bit positions: K0_MSB/LSB, K1_MSB/LSB, C_MSB/LSB, EN0_BIT, EN1_BIT, DAT_MSB/LSB, RSV_BIT, PAR_BIT.
- Sub-module sync_rise:
  - SYNC_STAGES flops plus one previous-value flop, with outputs level_s and rise.
  - Instanced for data_clk_cfg_pi and latch_cfg_pi; the level_s output alone is used for data_in_cfg_pi.

Test Plan:
- Reset then idle -> K0 = K1 = 2'b11, C = 2'b00, enable0/1 = 0, dat_ctl = 0, cfg_status_pi = 0, frame_err = 0, cfg_valid never pulses.
- Shift 16'hA9D4, then latch -> K0 = 2'b10, K1 = 2'b01, C = 2'b11, enable0 = 0, enable1 = 1, dat_ctl = 2'b01; cfg_valid one cycle exactly SYNC_STAGES+1 edges after latch is sampled high; cfg_status_pi = 1.
- Shift 16'hA9D5 (bad parity) after A9D4, then latch -> outputs hold the A9D4 values, frame_err = 1, cfg_status_pi = 0, no cfg_valid pulse; then A9D4 again -> frame_err = 0.
- Shift 16'h59D4 (bad sync, parity OK), and separately 17 bits then latch -> each is rejected with frame_err = 1.
- Shift 8 bits, idle TIMEOUT_CYC cycles (bench overrides it to 100) -> frame_err = 1; then a full A9D4 plus latch -> accepted.
- Assert RST_B low mid-frame after A9D4 was applied -> outputs return to reset values immediately, bit_cnt = 0.
- data_clk rise and latch rise in the same CLK cycle as the 16th bit -> accepted.
